// File: rtl/tg_axi_mem_responder_if.sv
// AXI4-MM bundle between the traffic generator initiator (master) and the memory responder (slave).
`timescale 1ns/1ps
interface tg_axi_mem_responder_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
) ();
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/tg_axi_mem_responder.sv
// AXI4-MM RAM responder: one write and one read INCR burst in flight, sticky error/burst counters.
// Optional random ready stalls when TG_RESP_BACKPRESSURE_EN is defined.
`timescale 1ns/1ps
module tg_axi_mem_responder #(
  parameter int ID_W      = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 512,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tg_axi_mem_responder_if.slave axi,
  output logic                 wlast_err,
  output logic [15:0]          wr_burst_cnt,
  output logic [15:0]          rd_burst_cnt
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic [7:0]        w_len, w_beat, r_len, r_beat;
  logic              w_err;
  logic [ID_W-1:0]   bid_q, rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              stall;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              w_last_beat, r_last_beat;

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    w = a >> OFF_W;
    return w[IDX_W-1:0];
  endfunction

`ifdef TG_RESP_BACKPRESSURE_EN
  // Pseudo-random stall source, restarted from the same seed on every reset
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign aw_hs       = axi.awvalid && axi.awready;
  assign w_hs        = axi.wvalid && axi.wready;
  assign b_hs        = axi.bvalid && axi.bready;
  assign ar_hs       = axi.arvalid && axi.arready;
  assign r_hs        = axi.rvalid && axi.rready;
  assign w_last_beat = (w_beat == w_len);
  assign r_last_beat = (r_beat == r_len);

  always_ff @(posedge clk) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Beat awlen always closes the burst; an early wlast is only flagged
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    axi.awready = rst_n && (w_state == W_IDLE) && !stall;
    axi.wready  = rst_n && (w_state == W_DATA) && !stall;
    axi.bvalid  = (w_state == W_RESP);
    axi.bresp   = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;
    axi.bid     = bid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_idx        <= '0;
      w_len        <= '0;
      w_beat       <= '0;
      w_err        <= 1'b0;
      bid_q        <= '0;
      wlast_err    <= 1'b0;
      wr_burst_cnt <= '0;
    end else begin
      if (aw_hs) begin
        bid_q  <= axi.awid;
        w_idx  <= word_index(axi.awaddr);
        w_len  <= axi.awlen;
        w_beat <= '0;
        w_err  <= 1'b0;
      end
      if (w_hs) begin
        w_idx  <= w_idx + IDX_W'(1);
        w_beat <= w_beat + 8'd1;
        if (axi.wlast != w_last_beat) begin
          w_err     <= 1'b1;
          wlast_err <= 1'b1;
        end
      end
      if (b_hs) wr_burst_cnt <= wr_burst_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: if (!stall) r_next = R_DATA;
      R_DATA:  if (axi.rready) r_next = r_last_beat ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    axi.arready = rst_n && (r_state == R_IDLE) && !stall;
    axi.rvalid  = (r_state == R_DATA);
    axi.rlast   = (r_state == R_DATA) && r_last_beat;
    axi.rid     = rid_q;
    axi.rdata   = rdata_q;
    axi.rresp   = 2'b00;
  end

  // rdata_q only loads in R_FETCH, so it holds steady while R_DATA waits on rready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      rid_q        <= '0;
      rdata_q      <= '0;
      rd_burst_cnt <= '0;
    end else begin
      if (ar_hs) begin
        rid_q  <= axi.arid;
        r_idx  <= word_index(axi.araddr);
        r_len  <= axi.arlen;
        r_beat <= '0;
      end
      if (r_state == R_FETCH) rdata_q <= mem[r_idx];
      if (r_hs) begin
        if (r_last_beat) begin
          rd_burst_cnt <= rd_burst_cnt + 16'd1;
        end else begin
          r_idx  <= r_idx + IDX_W'(1);
          r_beat <= r_beat + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tg_axi_mem_responder.sv
// Randomized self-checking bench for tg_axi_mem_responder against a byte-level RAM model.
`timescale 1ns/1ps
module tb_tg_axi_mem_responder;
  localparam int ID_W      = 8;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 512;
  localparam int MEM_DEPTH = 1024;
  localparam int BYTES     = DATA_W / 8;
  localparam int OFF_W     = $clog2(BYTES);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tg_axi_mem_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();
  logic        wlast_err;
  logic [15:0] wr_burst_cnt, rd_burst_cnt;

  tg_axi_mem_responder #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axi(axi),
    .wlast_err(wlast_err),
    .wr_burst_cnt(wr_burst_cnt),
    .rd_burst_cnt(rd_burst_cnt)
  );

  int numChecks = 0;
  int numPass   = 0;
  int expWrCnt  = 0;
  int expRdCnt  = 0;
  logic expWlastErr = 1'b0;
  logic [DATA_W-1:0] refMem [MEM_DEPTH];
  logic [DATA_W-1:0] wBeat [256];
  logic [BYTES-1:0]  wStrb [256];

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    numChecks++;
    if (actual === expected) numPass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  function automatic logic [DATA_W-1:0] randWord();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int wordIdx(input logic [ADDR_W-1:0] addr, input int beat);
    int base;
    base = int'(addr >> OFF_W);
    return (base + beat) % MEM_DEPTH;
  endfunction

  task automatic fillBeats(input int len, input bit randStrobes);
    logic [DATA_W-1:0] s;
    for (int i = 0; i <= len; i++) begin
      wBeat[i] = randWord();
      s = randWord();
      wStrb[i] = randStrobes ? s[BYTES-1:0] : '1;
    end
  endtask

  // Drive one write burst; earlyLast >= 0 places wlast on that beat instead of the final one
  task automatic writeBurst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input int len, input int earlyLast, input bit randBready);
    int   cyc;
    bit   err;
    logic acc;
    axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len); axi.awvalid = 1'b1;
    cyc = 0;
    do begin acc = axi.awready; @(posedge clk); #1; cyc++; end while (!acc && cyc < 100);
    axi.awvalid = 1'b0;
    if (!acc) begin checkOutput("aw_timeout", 0, 1); return; end
    err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(3) == 0) begin axi.wvalid = 1'b0; @(posedge clk); #1; end
      axi.wdata = wBeat[i];
      axi.wstrb = wStrb[i];
      axi.wlast = (earlyLast >= 0) ? (i == earlyLast) : (i == len);
      if (axi.wlast != (i == len)) err = 1'b1;
      axi.wvalid = 1'b1;
      cyc = 0;
      do begin acc = axi.wready; @(posedge clk); #1; cyc++; end while (!acc && cyc < 100);
      if (!acc) begin axi.wvalid = 1'b0; checkOutput("w_timeout", 0, 1); return; end
      for (int b = 0; b < BYTES; b++)
        if (wStrb[i][b]) refMem[wordIdx(addr, i)][b*8 +: 8] = wBeat[i][b*8 +: 8];
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    cyc = 0;
    do begin
      axi.bready = randBready ? 1'($urandom_range(1)) : 1'b1;
      acc = axi.bvalid && axi.bready;
      if (acc) begin
        checkOutput("bid", axi.bid, id);
        checkOutput("bresp", axi.bresp, err ? 2 : 0);
      end
      @(posedge clk); #1; cyc++;
    end while (!acc && cyc < 200);
    axi.bready = 1'b0;
    if (!acc) begin checkOutput("b_timeout", 0, 1); return; end
    expWrCnt++;
    if (err) expWlastErr = 1'b1;
    checkOutput("wr_burst_cnt", wr_burst_cnt, expWrCnt[15:0]);
    checkOutput("wlast_err", wlast_err, expWlastErr);
  endtask

  task automatic readBurst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input int len, input bit randRready);
    int   cyc, beat;
    logic acc, holdValid;
    logic [DATA_W-1:0] holdData;
    axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len); axi.arvalid = 1'b1;
    cyc = 0;
    do begin acc = axi.arready; @(posedge clk); #1; cyc++; end while (!acc && cyc < 100);
    axi.arvalid = 1'b0;
    if (!acc) begin checkOutput("ar_timeout", 0, 1); return; end
    beat = 0; cyc = 0; holdValid = 1'b0; holdData = '0;
    while (beat <= len && cyc < 2000) begin
      axi.rready = randRready ? 1'($urandom_range(1)) : 1'b1;
      if (holdValid) checkOutput("rdata_hold", axi.rdata, holdData);
      holdValid = axi.rvalid && !axi.rready;
      holdData  = axi.rdata;
      if (axi.rvalid && axi.rready) begin
        checkOutput("rdata", axi.rdata, refMem[wordIdx(addr, beat)]);
        checkOutput("rlast", axi.rlast, beat == len);
        checkOutput("rid", axi.rid, id);
        beat++;
      end
      @(posedge clk); #1; cyc++;
    end
    axi.rready = 1'b0;
    if (beat <= len) begin checkOutput("r_timeout", 0, 1); return; end
    expRdCnt++;
    checkOutput("rd_burst_cnt", rd_burst_cnt, expRdCnt[15:0]);
  endtask

  // Start a 16-beat read, then pull reset once beat 5 is presented
  task automatic applyStimulus();
    int   cyc, beats;
    logic acc;
    axi.arid = 8'h5A; axi.araddr = 32'h2000; axi.arlen = 8'd15; axi.arvalid = 1'b1;
    cyc = 0;
    do begin acc = axi.arready; @(posedge clk); #1; cyc++; end while (!acc && cyc < 100);
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 5 && cyc < 200) begin
      if (axi.rvalid) beats++;
      @(posedge clk); #1; cyc++;
    end
    checkOutput("rst_pre_beats", beats, 5);
    rst_n = 1'b0;
    axi.rready = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_rvalid", axi.rvalid, 0);
    checkOutput("rst_arready", axi.arready, 0);
    checkOutput("rst_bvalid", axi.bvalid, 0);
    @(posedge clk); #1;
    checkOutput("rst_wr_cnt", wr_burst_cnt, 0);
    checkOutput("rst_rd_cnt", rd_burst_cnt, 0);
    checkOutput("rst_wlast_err", wlast_err, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_arready", axi.arready, 1);
    checkOutput("rel_awready", axi.awready, 1);
    expWrCnt = 0; expRdCnt = 0; expWlastErr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_awready", axi.awready, 0);
    checkOutput("reset_wready", axi.wready, 0);
    checkOutput("reset_arready", axi.arready, 0);
    checkOutput("reset_bvalid", axi.bvalid, 0);
    checkOutput("reset_rvalid", axi.rvalid, 0);
    checkOutput("reset_bid", axi.bid, 0);
    checkOutput("reset_bresp", axi.bresp, 0);
    checkOutput("reset_rid", axi.rid, 0);
    checkOutput("reset_rdata", axi.rdata, 0);
    checkOutput("reset_rresp", axi.rresp, 0);
    checkOutput("reset_rlast", axi.rlast, 0);
    checkOutput("reset_wlast_err", wlast_err, 0);
    checkOutput("reset_wr_cnt", wr_burst_cnt, 0);
    checkOutput("reset_rd_cnt", rd_burst_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    wBeat[0] = {BYTES{8'hA5}};
    wStrb[0] = '1;
    writeBurst(8'h11, 32'h40, 0, -1, 1'b0);
    readBurst(8'h22, 32'h40, 0, 1'b0);

    fillBeats(3, 1'b0);
    writeBurst(8'h31, 32'h0, 3, -1, 1'b0);
    fillBeats(3, 1'b0);
    wStrb[2] = {{(BYTES/2){1'b0}}, {(BYTES/2){1'b1}}};
    writeBurst(8'h32, 32'h0, 3, -1, 1'b1);
    readBurst(8'h33, 32'h0, 3, 1'b1);

    fillBeats(3, 1'b0);
    writeBurst(8'h41, 32'h1000, 3, 1, 1'b0);
    fillBeats(1, 1'b0);
    writeBurst(8'h42, 32'h1000, 1, -1, 1'b0);
    readBurst(8'h43, 32'h1000, 3, 1'b0);

    fillBeats(1, 1'b0);
    writeBurst(8'h51, 32'((MEM_DEPTH - 1) * BYTES), 1, -1, 1'b0);
    readBurst(8'h52, 32'h0, 0, 1'b0);
    readBurst(8'h53, 32'((MEM_DEPTH - 1) * BYTES), 1, 1'b1);
    readBurst(8'h54, 32'(MEM_DEPTH * BYTES + 'h45), 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      logic [ADDR_W-1:0] a;
      int len;
      a   = $urandom();
      len = $urandom_range(15);
      fillBeats(len, 1'b0);
      writeBurst(8'($urandom()), a, len, -1, 1'b1);
      fillBeats(len, 1'b1);
      writeBurst(8'($urandom()), a, len, -1, 1'b1);
      readBurst(8'($urandom()), a, len, 1'b1);
    end

    fillBeats(15, 1'b0);
    writeBurst(8'h61, 32'(300 * BYTES), 15, -1, 1'b0);

    applyStimulus();

    fillBeats(15, 1'b0);
    fork
      writeBurst(8'h71, 32'(500 * BYTES), 15, -1, 1'b1);
      readBurst(8'h72, 32'(300 * BYTES), 15, 1'b1);
    join
    checkOutput("conc_wr_cnt", wr_burst_cnt, 1);
    checkOutput("conc_rd_cnt", rd_burst_cnt, 1);
    readBurst(8'h73, 32'(500 * BYTES), 15, 1'b0);

    $display("[TB] %0d/%0d checks passed", numPass, numChecks);
    $finish;
  end
endmodule

// File: doc/tg_axi_mem_responder.md
Name: tg_axi_mem_responder

Overview:
- AXI4-MM subordinate (responder) that terminates the memory traffic generator's initiator port in simulation and in loopback builds, in place of the EMIF.
- Backed by a word-addressed RAM of MEM_DEPTH × DATA_W.
- Handles one write burst and one read burst concurrently (one outstanding per direction); INCR bursts only, full-width beats.
- Exposes sticky protocol-error and burst-completion counters for CSR readback.

Parameters:
ID_W, 8, AXI ID width
ADDR_W, 32, byte address width
DATA_W, 512, data beat width; power of 2, ≥32
MEM_DEPTH, 1024, RAM depth in DATA_W words; power of 2

Ports:
clk  in  1  responder clock
rst_n  in  1  synchronous active-low reset
awid  in  ID_W  write burst ID
awaddr  in  ADDR_W  write start byte address
awlen  in  8  write beats minus 1
awvalid  in  1  write address valid
awready  out  1  write address accept
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  final write beat marker
wvalid  in  1  write data valid
wready  out  1  write data accept
bid  out  ID_W  response ID (captured awid)
bresp  out  2  2'b00 OKAY / 2'b10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response accept
arid  in  ID_W  read burst ID
araddr  in  ADDR_W  read start byte address
arlen  in  8  read beats minus 1
arvalid  in  1  read address valid
arready  out  1  read address accept
rid  out  ID_W  read ID (captured arid)
rdata  out  DATA_W  read data
rresp  out  2  always 2'b00
rlast  out  1  final read beat
rvalid  out  1  read data valid
rready  in  1  read data accept
wlast_err  out  1  sticky: wlast mismatch seen
wr_burst_cnt  out  16  completed B handshakes, wraps
rd_burst_cnt  out  16  completed rlast handshakes, wraps

Behaviour:
- Clock clk; reset rst_n, synchronous, active-low.
- During and after reset, all outputs are 0: ready/valid signals, bid, bresp, rid, rdata, rresp, rlast, wlast_err, and both counters. RAM contents are not reset.
- Word index = byte address >> log2(DATA_W/8), taken modulo MEM_DEPTH. The index increments by 1 per beat and wraps from MEM_DEPTH-1 to 0. Unaligned low address bits are ignored.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid, capture awid, index and awlen; clear the beat count and the error flag; go to W_DATA.
  - W_DATA: wready=1, awready=0. Each wvalid beat writes the bytes selected by wstrb at the current index.
  - wlast mismatch: wlast=1 before beat awlen, or wlast=0 on beat awlen. Either sets the burst error flag and the sticky wlast_err.
  - Beat awlen always ends the burst and moves to W_RESP; early wlast does not end it.
  - W_RESP: bvalid=1, bresp=SLVERR if the error flag is set, else OKAY. Hold until bready, then increment wr_burst_cnt and go to W_IDLE.
- Read FSM states: R_IDLE, R_FETCH, R_DATA.
  - R_IDLE: arready=1. On arvalid, capture arid, index and arlen; go to R_FETCH.
  - R_FETCH: the RAM read issues (1-cycle RAM latency); go to R_DATA.
  - R_DATA: rvalid=1, rlast=(beat==arlen). rdata, rid and rlast stay stable until rready.
  - On the R_DATA handshake: if last, increment rd_burst_cnt and go to R_IDLE; otherwise advance the index and return to R_FETCH.
  - Throughput is 1 beat per 2 cycles.
- Read/write collision on the same index in the same cycle: the read returns the old data.
- awlen=0 or arlen=0 means a single beat; awlen=255 means 256 beats, which may wrap the RAM.
- Reset asserted mid-burst aborts both FSMs to IDLE and drops all valids the next cycle.

Optional Feature:
- Macro: TG_RESP_BACKPRESSURE_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) advances every cycle.
  - When lfsr[1:0]==2'b00, awready, wready and arready are forced to 0 that cycle.
  - When lfsr[1:0]==2'b00, R_FETCH→R_DATA is delayed by one cycle.
  - bvalid is never suppressed once asserted.
- When not defined: no stalls; timing exactly as specified above.

Test Plan:
- Single write: awaddr=0x40, awlen=0, wdata=all-A5, wstrb all-1s, wlast=1 → B handshake with bresp=00, bid=awid; then a read of the same address returns all-A5, rlast=1, rd_burst_cnt=1.
- Burst with strobes: awlen=3 at index 0 with wstrb=lower half only on beat 2; read back with arlen=3 → beat 2 upper half keeps its prior contents, other beats match written data.
- wlast error: awlen=3 with wlast asserted on beat 1 → 4 beats still accepted, bresp=10, wlast_err=1 and stays 1 through later OKAY bursts.
- Wrap: write 2 beats at index MEM_DEPTH-1 → second beat lands at index 0, confirmed by readback.
- Concurrency/backpressure: overlapping 16-beat write and read with rready/bready toggling 50%; rdata held stable while rvalid && !rready; counters end at wr=1, rd=1.
- Reset during a 16-beat read at beat 5 → rvalid=0 next cycle, arready=1 after release, wr_burst_cnt/rd_burst_cnt=0.
